inst_queue: RTL

Instruction queue between the fetch stage and the decode stage. Buffers fetched `{pc, inst}` pairs in a small circular FIFO so fetch can keep running while decode stalls. Supports a single-cycle flush for redirects and tags each entry with a precomputed "not a 32-bit encoding" flag. Enqueue side faces fetch; dequeue side faces decode; both use valid/ready handshakes.

---
 rtl/inst_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, inst, illegal} with single-cycle flush.
// Optional stall counter enabled by defining INST_QUEUE_STALL_CNT_EN.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_illegal,
    input  logic                     out_ready,
`ifdef INST_QUEUE_STALL_CNT_EN
    output logic [63:0]              stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          ill_mem  [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic          enq;
    logic          deq;

    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;
    assign count     = cnt;

    always_comb begin
        out_pc      = '0;
        out_inst    = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = pc_mem[rptr];
            out_inst    = inst_mem[rptr];
            out_illegal = ill_mem[rptr];
        end
    end

    // Slot contents are left unreset; only pointers and occupancy matter.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wptr]   <= in_pc;
            inst_mem[wptr] <= in_inst;
            ill_mem[wptr]  <= (in_inst[1:0] != 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (enq) wptr <= wptr + AW'(1);
            if (deq) rptr <= rptr + AW'(1);
            case ({enq, deq})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef INST_QUEUE_STALL_CNT_EN
    // Flush does not clear this; it tracks fetch back-pressure over the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 64'd1;
        end
    end
`endif

endmodule
